// File: rtl/ofdm_demodulation_if.sv
// Sample-in / byte-out handshake bundle for the OFDM hard-decision demapper.
// The slave modport is the demapper's view; master is the surrounding environment.
interface ofdm_demodulation_if #(
    parameter int DATA_SIZE = 16
);
    logic                 i_valid;
    logic [DATA_SIZE-1:0] i_data_i;
    logic [DATA_SIZE-1:0] i_data_q;
    logic [2:0]           i_modulation;
    logic                 i_last;
    logic                 o_wayt_data;
    logic [7:0]           o_data;
    logic                 o_valid_data;
    logic                 o_last;
    logic                 i_wayt_res_data;
    logic                 o_error;

    modport slave (
        input  i_valid, i_data_i, i_data_q, i_modulation, i_last, i_wayt_res_data,
        output o_wayt_data, o_data, o_valid_data, o_last, o_error
    );

    modport master (
        output i_valid, i_data_i, i_data_q, i_modulation, i_last, i_wayt_res_data,
        input  o_wayt_data, o_data, o_valid_data, o_last, o_error
    );
endinterface

// File: rtl/ofdm_demodulation.sv
// Hard-slices I/Q subcarrier samples to Gray-coded BPSK/QPSK/16-QAM/64-QAM bits
// and packs them MSB-first into bytes, with a per-frame zero-padded flush.
module ofdm_demodulation #(
    parameter int          DATA_SIZE = 16,
    parameter logic [15:0] STEP      = 16'd2048
) (
    input logic                i_clk,
    input logic                i_reset,
    ofdm_demodulation_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

    localparam logic [DATA_SIZE+1:0] STEP_X2 = (DATA_SIZE+2)'({STEP, 1'b0});
    localparam logic [DATA_SIZE+1:0] STEP_X4 = (DATA_SIZE+2)'({STEP, 2'b00});

    state_t      state_reg, state_next;
    logic [15:0] acc_reg, acc_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [7:0]  o_data_reg;
    logic        o_valid_reg;
    logic        o_last_reg;
    logic        o_error_reg;

    logic [1:0][DATA_SIZE-1:0] axis_x;
    logic [1:0] b0_vec, b1q16_vec, b1q64_vec, b2_vec;
    logic [5:0] sym_top;
    logic [4:0] k;
    logic       mod_ok;
    logic       out_free, emit_full, emit, emit_last, accept;
    logic [4:0] cnt_kept, fill;

    assign axis_x = {bus.i_data_q, bus.i_data_i};

    // Per-axis slicer; magnitude is one bit wider so the most negative input cannot overflow.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slice
            logic [DATA_SIZE:0]   x_ext;
            logic [DATA_SIZE:0]   mag;
            logic [DATA_SIZE+1:0] diff;
            logic [DATA_SIZE+1:0] diff_mag;

            assign x_ext         = {axis_x[gi][DATA_SIZE-1], axis_x[gi]};
            assign mag           = x_ext[DATA_SIZE] ? -x_ext : x_ext;
            assign diff          = {1'b0, mag} - STEP_X4;
            assign diff_mag      = diff[DATA_SIZE+1] ? -diff : diff;
            assign b0_vec[gi]    = ~x_ext[DATA_SIZE];
            assign b1q16_vec[gi] = ({1'b0, mag} < STEP_X2);
            assign b1q64_vec[gi] = ({1'b0, mag} < STEP_X4);
            assign b2_vec[gi]    = (diff_mag < STEP_X2);
        end
    endgenerate

    // Symbol bits left-aligned in a 6-bit field, first bit at the top.
    always_comb begin
        sym_top = 6'd0;
        k       = 5'd0;
        mod_ok  = 1'b1;
        case (bus.i_modulation)
            3'd1: begin
                sym_top = {b0_vec[0], 5'b0};
                k       = 5'd1;
            end
            3'd2: begin
                sym_top = {b0_vec[0], b0_vec[1], 4'b0};
                k       = 5'd2;
            end
            3'd4: begin
                sym_top = {b0_vec[0], b1q16_vec[0], b0_vec[1], b1q16_vec[1], 2'b0};
                k       = 5'd4;
            end
            3'd6: begin
                sym_top = {b0_vec[0], b1q64_vec[0], b2_vec[0], b0_vec[1], b1q64_vec[1], b2_vec[1]};
                k       = 5'd6;
            end
            default: mod_ok = 1'b0;
        endcase
    end

    assign out_free        = !o_valid_reg || bus.i_wayt_res_data;
    assign emit_full       = (cnt_reg >= 5'd8) && out_free;
    assign cnt_kept        = emit_full ? cnt_reg - 5'd8 : cnt_reg;
    assign fill            = cnt_kept + k;
    assign bus.o_wayt_data = i_reset && (state_reg != ST_FLUSH) && (fill <= 5'd16);
    assign accept          = bus.i_valid && bus.o_wayt_data;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        emit       = 1'b0;
        emit_last  = 1'b0;
        case (state_reg)
            ST_FLUSH: begin
                if (cnt_reg == 5'd0) begin
                    state_next = ST_IDLE;
                end else if (out_free) begin
                    // A short residue goes out as-is: bits below it are already zero.
                    emit     = 1'b1;
                    acc_next = acc_reg << 8;
                    if (cnt_reg <= 5'd8) begin
                        emit_last  = 1'b1;
                        cnt_next   = 5'd0;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg - 5'd8;
                    end
                end
            end
            default: begin
                emit = emit_full;
                if (emit_full) begin
                    acc_next = acc_reg << 8;
                    cnt_next = cnt_kept;
                end
                if (accept) begin
                    acc_next = acc_next | ({sym_top, 10'b0} >> cnt_kept);
                    cnt_next = fill;
                    if (bus.i_last) begin
                        if (fill == 5'd0) begin
                            state_next = ST_IDLE;
                            emit_last  = emit_full;
                        end else begin
                            state_next = ST_FLUSH;
                        end
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_reg   <= ST_IDLE;
            acc_reg     <= 16'd0;
            cnt_reg     <= 5'd0;
            o_data_reg  <= 8'd0;
            o_valid_reg <= 1'b0;
            o_last_reg  <= 1'b0;
            o_error_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            o_error_reg <= accept && !mod_ok;
            if (emit) begin
                o_data_reg  <= acc_reg[15:8];
                o_valid_reg <= 1'b1;
                o_last_reg  <= emit_last;
            end else if (bus.i_wayt_res_data) begin
                o_valid_reg <= 1'b0;
                o_last_reg  <= 1'b0;
            end
        end
    end

    assign bus.o_data       = o_data_reg;
    assign bus.o_valid_data = o_valid_reg;
    assign bus.o_last       = o_last_reg;
    assign bus.o_error      = o_error_reg;
endmodule

// File: tb/tb_ofdm_demodulation.sv
// Self-checking bench for ofdm_demodulation: directed scenarios plus randomized
// frames scored against a bit-queue reference model of the slicing and packing rules.
module tb_ofdm_demodulation;
    localparam int S = 2048;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];
    bit         frame_bits[$];

    ofdm_demodulation_if #(.DATA_SIZE(16)) bus ();

    ofdm_demodulation #(.DATA_SIZE(16), .STEP(16'd2048)) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference slicer: returns {b0, b1, b2} for one axis.
    function automatic logic [2:0] slice_axis(input int x, input bit is64);
        int a;
        int d;
        logic [2:0] r;
        a = (x < 0) ? -x : x;
        d = a - 4 * S;
        if (d < 0) d = -d;
        r[2] = (x >= 0);
        r[1] = is64 ? (a < 4 * S) : (a < 2 * S);
        r[0] = (d < 2 * S);
        return r;
    endfunction

    task automatic model_accept(input int xi, input int xq, input logic [2:0] m, input logic l);
        logic [2:0] si;
        logic [2:0] sq;
        logic [7:0] b;
        si = slice_axis(xi, (m == 3'd6));
        sq = slice_axis(xq, (m == 3'd6));
        case (m)
            3'd1: frame_bits.push_back(si[2]);
            3'd2: begin frame_bits.push_back(si[2]); frame_bits.push_back(sq[2]); end
            3'd4: begin
                frame_bits.push_back(si[2]); frame_bits.push_back(si[1]);
                frame_bits.push_back(sq[2]); frame_bits.push_back(sq[1]);
            end
            3'd6: begin
                frame_bits.push_back(si[2]); frame_bits.push_back(si[1]); frame_bits.push_back(si[0]);
                frame_bits.push_back(sq[2]); frame_bits.push_back(sq[1]); frame_bits.push_back(sq[0]);
            end
            default: ;
        endcase
        while (frame_bits.size() > 8) begin
            b = 8'd0;
            for (int j = 0; j < 8; j++) b = {b[6:0], frame_bits.pop_front()};
            exp_q.push_back({1'b0, b});
        end
        if (l && frame_bits.size() > 0) begin
            b = 8'd0;
            for (int j = 0; j < 8; j++) b = {b[6:0], (frame_bits.size() > 0) ? frame_bits.pop_front() : 1'b0};
            exp_q.push_back({1'b1, b});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.i_valid && bus.o_wayt_data)
                model_accept(int'($signed(bus.i_data_i)), int'($signed(bus.i_data_q)), bus.i_modulation, bus.i_last);
            if (bus.o_valid_data && bus.i_wayt_res_data) begin
                obs_q.push_back({bus.o_last, bus.o_data});
                $display("byte data=%02h last=%0b", bus.o_data, bus.o_last);
            end
        end
    end

    task automatic send(input int xi, input int xq, input logic [2:0] m, input logic l, output int waited);
        waited = 0;
        bus.i_valid      = 1'b1;
        bus.i_data_i     = 16'(xi);
        bus.i_data_q     = 16'(xq);
        bus.i_modulation = m;
        bus.i_last       = l;
        @(negedge clk);
        while (!bus.o_wayt_data && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.o_wayt_data) begin
            checks++; errors++;
            $display("FAIL send_timeout ready=%0b required=1", bus.o_wayt_data);
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.o_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%02h exp=00", bus.o_data); end
        checks++; if (bus.o_valid_data !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.o_valid_data); end
        checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%0b exp=0", bus.o_last); end
        checks++; if (bus.o_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", bus.o_error); end
        checks++; if (bus.o_wayt_data !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", bus.o_wayt_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_wayt_data !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%0b exp=1", bus.o_wayt_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_qam16();
        int w;
        obs_q.delete(); exp_q.delete();
        bus.i_wayt_res_data = 1'b1;
        send(3 * S, -S, 3'd4, 1'b0, w);
        send(-S, S, 3'd4, 1'b1, w);
        @(negedge clk);
        checks++; if (bus.o_valid_data !== 1'b0) begin errors++; $display("FAIL qam16_early_valid got=%0b exp=0", bus.o_valid_data); end
        checks++; if (bus.o_wayt_data !== 1'b0) begin errors++; $display("FAIL qam16_flush_ready got=%0b exp=0", bus.o_wayt_data); end
        @(negedge clk);
        checks++; if (bus.o_valid_data !== 1'b1) begin errors++; $display("FAIL qam16_valid got=%0b exp=1", bus.o_valid_data); end
        checks++; if (bus.o_data !== 8'h97) begin errors++; $display("FAIL qam16_data got=%02h exp=97", bus.o_data); end
        checks++; if (bus.o_last !== 1'b1) begin errors++; $display("FAIL qam16_last got=%0b exp=1", bus.o_last); end
        @(negedge clk);
        checks++; if (bus.o_valid_data !== 1'b0) begin errors++; $display("FAIL qam16_valid_width got=%0b exp=0", bus.o_valid_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_qam64_last();
        int w;
        obs_q.delete(); exp_q.delete();
        bus.i_wayt_res_data = 1'b1;
        for (int s = 0; s < 3; s++)
            send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 3'd6, (s == 2), w);
        @(negedge clk);
        checks++; if (bus.o_wayt_data !== 1'b0) begin errors++; $display("FAIL qam64_flush_ready got=%0b exp=0", bus.o_wayt_data); end
        w = 0;
        while (obs_q.size() < 3 && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL qam64_count got=%0d exp=3", obs_q.size()); end
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
            checks++;
            if (obs_q[j] !== exp_q[j]) begin errors++; $display("FAIL qam64_byte%0d got=%03h exp=%03h", j, obs_q[j], exp_q[j]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int w;
        int total_wait;
        obs_q.delete(); exp_q.delete();
        bus.i_wayt_res_data = 1'b1;
        total_wait = 0;
        for (int s = 0; s < 8; s++) begin
            send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 3'd6, (s == 7), w);
            total_wait += w;
        end
        checks++; if (total_wait != 0) begin errors++; $display("FAIL b2b_stall got=%0d exp=0", total_wait); end
        w = 0;
        while (obs_q.size() < 6 && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", obs_q.size()); end
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
            checks++;
            if (obs_q[j] !== exp_q[j]) begin errors++; $display("FAIL b2b_byte%0d got=%03h exp=%03h", j, obs_q[j], exp_q[j]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int   accepted;
        int   w;
        bit   stable;
        bit   got;
        logic [7:0] held;
        obs_q.delete(); exp_q.delete();
        bus.i_wayt_res_data = 1'b0;
        accepted = 0;
        bus.i_valid = 1'b1;
        bus.i_modulation = 3'd1;
        bus.i_last = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.i_data_i = ($urandom_range(0, 1) != 0) ? 16'(S) : 16'(-S);
            bus.i_data_q = 16'($urandom_range(0, 65535));
            @(negedge clk);
            got = bus.o_wayt_data;
            if (got) accepted++;
            @(posedge clk); #1;
            if (!got) break;
        end
        bus.i_valid = 1'b0;
        checks++; if (accepted != 24) begin errors++; $display("FAIL bp_accepted got=%0d exp=24", accepted); end
        @(negedge clk);
        held = bus.o_data;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.o_data !== held || bus.o_valid_data !== 1'b1 || bus.o_wayt_data !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_hold got=%02h exp=%02h", bus.o_data, held); end
        @(posedge clk); #1;
        bus.i_wayt_res_data = 1'b1;
        send(S, 0, 3'd1, 1'b1, w);
        w = 0;
        while (obs_q.size() < 4 && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", obs_q.size()); end
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
            checks++;
            if (obs_q[j] !== exp_q[j]) begin errors++; $display("FAIL bp_byte%0d got=%03h exp=%03h", j, obs_q[j], exp_q[j]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_invalid_mod();
        int w;
        obs_q.delete(); exp_q.delete();
        bus.i_wayt_res_data = 1'b1;
        send(S, -S, 3'd2, 1'b0, w);
        @(negedge clk);
        checks++; if (bus.o_error !== 1'b0) begin errors++; $display("FAIL inv_error_pre got=%0b exp=0", bus.o_error); end
        @(posedge clk); #1;
        send(3 * S, 3 * S, 3'd3, 1'b0, w);
        @(negedge clk);
        checks++; if (bus.o_error !== 1'b1) begin errors++; $display("FAIL inv_error_pulse got=%0b exp=1", bus.o_error); end
        @(negedge clk);
        checks++; if (bus.o_error !== 1'b0) begin errors++; $display("FAIL inv_error_width got=%0b exp=0", bus.o_error); end
        checks++; if (bus.o_valid_data !== 1'b0) begin errors++; $display("FAIL inv_no_output got=%0b exp=0", bus.o_valid_data); end
        @(posedge clk); #1;
        send(-S, S, 3'd2, 1'b1, w);
        w = 0;
        while (obs_q.size() < 1 && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL inv_count got=%0d exp=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== 9'h190) begin errors++; $display("FAIL inv_byte got=%03h exp=190", obs_q[0]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        int w;
        logic [7:0] pattern;
        obs_q.delete(); exp_q.delete();
        bus.i_wayt_res_data = 1'b0;
        for (int s = 0; s < 13; s++) send(-S, 0, 3'd1, 1'b0, w);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.o_valid_data !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%0b exp=0", bus.o_valid_data); end
        checks++; if (bus.o_data !== 8'd0) begin errors++; $display("FAIL mid_reset_data got=%02h exp=00", bus.o_data); end
        checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL mid_reset_last got=%0b exp=0", bus.o_last); end
        checks++; if (bus.o_wayt_data !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%0b exp=0", bus.o_wayt_data); end
        obs_q.delete(); exp_q.delete(); frame_bits.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.i_wayt_res_data = 1'b1;
        pattern = 8'hB2;
        for (int s = 0; s < 8; s++) send(pattern[7 - s] ? S : -S, 0, 3'd1, (s == 7), w);
        w = 0;
        while (obs_q.size() < 1 && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL post_reset_count got=%0d exp=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== 9'h1B2) begin errors++; $display("FAIL post_reset_byte got=%03h exp=1b2", obs_q[0]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_slicer_bounds();
        int w;
        obs_q.delete(); exp_q.delete();
        bus.i_wayt_res_data = 1'b1;
        send(0, 2 * S, 3'd4, 1'b0, w);
        send(2 * S - 1, -32768, 3'd4, 1'b1, w);
        w = 0;
        while (obs_q.size() < 1 && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL bounds_count got=%0d exp=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== 9'h1EC) begin errors++; $display("FAIL bounds_byte got=%03h exp=1ec", obs_q[0]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_frames();
        logic [2:0] mods[4] = '{3'd1, 3'd2, 3'd4, 3'd6};
        logic [2:0] bad[4]  = '{3'd0, 3'd3, 3'd5, 3'd7};
        int   len, wc, w, xi, xq;
        bit   lst, got;
        logic [2:0] m;
        obs_q.delete(); exp_q.delete();
        for (int f = 0; f < 14; f++) begin
            len = $urandom_range(1, 10);
            for (int s = 0; s < len; s++) begin
                lst = (s == len - 1);
                m = mods[$urandom_range(0, 3)];
                if (!lst && $urandom_range(0, 9) == 0) m = bad[$urandom_range(0, 3)];
                if ($urandom_range(0, 1) != 0) begin
                    xi = (int'($urandom_range(0, 15)) - 8) * S + int'($urandom_range(0, 4)) - 2;
                    xq = (int'($urandom_range(0, 15)) - 8) * S + int'($urandom_range(0, 4)) - 2;
                end else begin
                    xi = int'($urandom_range(0, 65535)) - 32768;
                    xq = int'($urandom_range(0, 65535)) - 32768;
                end
                bus.i_valid = 1'b1; bus.i_data_i = 16'(xi); bus.i_data_q = 16'(xq);
                bus.i_modulation = m; bus.i_last = lst;
                wc = 0;
                do begin
                    bus.i_wayt_res_data = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    got = bus.o_wayt_data;
                    @(posedge clk); #1;
                    wc++;
                end while (!got && wc < 300);
                if (!got) begin checks++; errors++; $display("FAIL rand_send_timeout ready=%0b required=1", got); end
                bus.i_valid = 1'b0; bus.i_last = 1'b0;
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
        end
        bus.i_wayt_res_data = 1'b1;
        w = 0;
        while (obs_q.size() < exp_q.size() && w < 200) begin @(negedge clk); w++; end
        repeat (5) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
            checks++;
            if (obs_q[j] !== exp_q[j]) begin errors++; $display("FAIL rand_byte%0d got=%03h exp=%03h", j, obs_q[j], exp_q[j]); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data_i = '0;
        bus.i_data_q = '0;
        bus.i_modulation = 3'd0;
        bus.i_last = 1'b0;
        bus.i_wayt_res_data = 1'b1;
        test_reset();
        test_qam16();
        test_qam64_last();
        test_back_to_back();
        test_backpressure();
        test_invalid_mod();
        test_reset_mid_frame();
        test_slicer_bounds();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ofdm_demodulation.md
# ofdm_demodulation

Receive-side counterpart of the OFDM symbol mapper. The block takes frequency-domain I/Q subcarrier samples from the forward FFT, hard-slices each sample to BPSK/QPSK/16-QAM/64-QAM bits using the team's Gray mapping, and packs the bits MSB-first into bytes for the downstream byte consumer. It uses a ready/valid handshake on both sides and supports a per-frame `i_last` flush that emits a final zero-padded byte.

## Interface
- DATA_SIZE, 16: width of the signed two's-complement I/Q input samples.
- STEP, 16'd2048: constellation half-spacing. Points sit at odd multiples of STEP on each axis (±1, ±3, ±5, ±7 × STEP).

- i_clk  in  1  clock; everything is on the rising edge.
- i_reset  in  1  synchronous reset, active-low.
- i_valid  in  1  input I/Q sample valid.
- i_data_i  in  DATA_SIZE  signed I sample.
- i_data_q  in  DATA_SIZE  signed Q sample.
- i_modulation  in  3  bits per symbol: 1=BPSK, 2=QPSK, 4=16-QAM, 6=64-QAM; any other value is invalid.
- i_last  in  1  qualifies the final sample of a frame.
- o_wayt_data  out  1  ready to accept a sample.
- o_data  out  8  demapped byte.
- o_valid_data  out  1  o_data valid.
- o_last  out  1  marks the final byte of a frame; valid only with o_valid_data.
- i_wayt_res_data  in  1  downstream ready.
- o_error  out  1  one-cycle pulse when a sample is accepted with an invalid i_modulation.

## Operation
- **Accept:** a sample is accepted when `i_valid && o_wayt_data`. i_modulation and i_last are sampled with the same sample.
- **Slicing (combinational):** for x = I or Q, |x| is computed in DATA_SIZE+1 bits with no overflow.
  - b0 = (x >= 0).
  - 16-QAM: b1 = (|x| < 2·STEP).
  - 64-QAM: b1 = (|x| < 4·STEP); b2 = (abs(|x| − 4·STEP) < 2·STEP).
  - BPSK uses the I sign bit only. Q is ignored.
  - Symbol bit order, first to last: I bits (b0, b1, b2), then Q bits.
- **Accumulator:** 16-bit shift register `acc`, with bit count `cnt` ranging 0..16.
  - New bits are appended below the existing bits.
  - The oldest bit becomes o_data[7].
- **Emit:** `emit = (cnt >= 8) && (!o_valid_data || i_wayt_res_data)`.
  - On emit, the top 8 valid bits load o_data, o_valid_data is set, and cnt decreases by 8.
  - Accept and emit can happen in the same cycle: cnt_next = cnt − 8·emit + k.
- **Ready:** `o_wayt_data = i_reset && !flushing && (cnt − 8·emit + k ≤ 16)`, where k is the bit count for the current i_modulation.
- **Flush FSM, states IDLE / RUN / FLUSH:**
  - IDLE → RUN on the first accepted sample.
  - RUN → FLUSH when a sample with i_last is accepted.
  - In FLUSH, o_wayt_data = 0. Full bytes are emitted normally.
  - If 0 < cnt < 8 remains, the residue is left-aligned, zero-padded to 8 bits and emitted as one byte.
  - The final emitted byte carries o_last = 1. FLUSH → IDLE on that emit.
  - If i_last arrives and cnt − 8·emit + k is 0, o_last goes on the last full byte instead, or on no byte if none is pending.
- **Invalid i_modulation:** the sample is accepted and contributes no bits; o_error pulses on the next cycle. If the sample also carries i_last, the flush still occurs.
- **o_valid_data** clears on `i_wayt_res_data` when no new emit occurs in that cycle. o_data and o_last are held stable while `o_valid_data && !i_wayt_res_data`.

## Timing
- **Reset** (i_reset = 0 at an edge):
  - o_data = 0, o_valid_data = 0, o_last = 0, o_error = 0.
  - cnt = 0, acc = 0, FSM = IDLE.
  - o_wayt_data is 0 while i_reset = 0.
- **Reset mid-frame:** all partial bits and any pending byte are discarded with no output.
- **Latency:** the byte completed by a sample accepted at edge E has o_valid_data high after edge E+1, provided the output register is free.
- **Throughput**, with downstream always ready: one sample per cycle for every modulation. Bytes are produced at the matching rate: BPSK one per 8 cycles, QPSK one per 4, 16-QAM one per 2, 64-QAM three per 4.
- **Backpressure:** with `i_wayt_res_data = 0`, at most 8 bits in o_data plus up to 16 bits in acc are held. o_wayt_data then drops, and no bits are ever lost or duplicated.
- **Boundaries:**
  - Exactly 8 residual bits at i_last: emitted as a normal byte with o_last = 1 and no pad.
  - cnt = 16 with the output register full: o_wayt_data = 0.

## Test plan
- **16-QAM, downstream ready.** Stimulus, STEP = 2048: (I,Q) = (+3S, −1S) then (−1S, +1S) → samples accepted on consecutive cycles.
  - Bits: 1 0 0 1, then 0 1 1 1.
  - o_data = 8'h97, valid 2 cycles after the second accept; o_valid_data high exactly 1 cycle.
- **64-QAM stream with i_last on the 3rd sample.** 18 bits → two bytes, then a third byte holding 2 residual bits zero-padded (e.g. 8'hC0 for residual 11). o_last = 1 on the third byte only; o_wayt_data = 0 during FLUSH.
- **BPSK, i_wayt_res_data held low 20 cycles.** o_wayt_data falls after 24 bits are buffered. o_data holds stable; on release, the three bytes arrive in order with no loss.
- **Modulation = 3'd3.** The sample is accepted; o_error = 1 for exactly one cycle; cnt and the output are unchanged.
- **Reset mid-frame.** i_reset = 0 with cnt = 5 and o_valid_data = 1 → next cycle, all outputs are 0 and cnt = 0. The first byte after reset contains only post-reset bits.
- **Slicer boundaries, 16-QAM.** I = 0 → b0 = 1; I = +2S → b1 = 0; I = +2S−1 → b1 = 1; I = −32768 → b0 = 0, b1 = 0 with no overflow.
